// File: rtl/ntt_bfly_post_if.sv
// Port bundle for the butterfly back-end: operands in, butterfly pair out.
// Handshake: valid-only. in_valid qualifies u_in/in_intt in the same cycle, and t_in follows DLY
// cycles later. out_valid qualifies out_add/out_sub. There is no ready: every item is accepted.
interface ntt_bfly_post_if #(
  parameter int LOGQ = 60
);
  logic [LOGQ-1:0] q;
  logic            in_valid;
  logic            in_intt;
  logic [LOGQ-1:0] u_in;
  logic [LOGQ-1:0] t_in;
  logic            out_valid;
  logic [LOGQ-1:0] out_add;
  logic [LOGQ-1:0] out_sub;

  modport master (
    output q, in_valid, in_intt, u_in, t_in,
    input  out_valid, out_add, out_sub
  );

  modport slave (
    input  q, in_valid, in_intt, u_in, t_in,
    output out_valid, out_add, out_sub
  );
endinterface

// File: rtl/ntt_bfly_post.sv
// Butterfly back-end: aligns u with the wlmont twiddle product t and produces (u+t, u-t) mod q,
// optionally halved mod q for the inverse transform. Fixed latency DLY+3, one item per cycle.
module ntt_bfly_post #(
  parameter int LOGQ   = 60,
  parameter int W      = 15,
  parameter int L      = 4,
  parameter int MULLAT = 1,
  parameter int ADDPIP = 0
) (
  input logic           clk,
  input logic           rst_n,
  ntt_bfly_post_if.slave bf
);

  // Must track the wlmont pipeline depth exactly, or u and t will not meet.
  localparam int DLY = L * MULLAT
                     + (((LOGQ - W) <= 24) ? ((2 * LOGQ - 47) / W) * (ADDPIP + 1)
                                           : L * (ADDPIP + 1))
                     + (ADDPIP + 1);

  logic [DLY-1:0]  dl_v;
  logic [DLY-1:0]  dl_i;
  logic [LOGQ-1:0] dl_u [DLY];

  logic            s1_v, s1_i;
  logic [LOGQ:0]   s1_sum, s1_dif;
  logic            s2_v, s2_i;
  logic [LOGQ-1:0] s2_a, s2_s;
  logic            o_v;
  logic [LOGQ-1:0] o_add, o_sub;

  logic [LOGQ:0]   q_ext;
  logic [LOGQ-1:0] a_red, s_red;
  logic [LOGQ-1:0] h_add, h_sub;

  assign q_ext = {1'b0, bf.q};

  // S2 reduction: sum lies in [0,2q), dif in (-q,q), so one correction suffices.
  always_comb begin
    a_red = LOGQ'((s1_sum >= q_ext) ? (s1_sum - q_ext) : s1_sum);
    s_red = LOGQ'(s1_dif[LOGQ] ? (s1_dif + q_ext) : s1_dif);
  end

  // S3 halving: q is odd, so x+q is even whenever x is odd and the shift is exact.
  always_comb begin
    h_add = LOGQ'(({1'b0, s2_a} + (s2_a[0] ? q_ext : '0)) >> 1);
    h_sub = LOGQ'(({1'b0, s2_s} + (s2_s[0] ? q_ext : '0)) >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_v <= '0;
      dl_i <= '0;
      for (int i = 0; i < DLY; i++) dl_u[i] <= '0;
    end else begin
      dl_v[0] <= bf.in_valid;
      dl_i[0] <= bf.in_intt;
      dl_u[0] <= bf.u_in;
      for (int i = 1; i < DLY; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_i[i] <= dl_i[i-1];
        dl_u[i] <= dl_u[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_i   <= 1'b0;
      s1_sum <= '0;
      s1_dif <= '0;
      s2_v   <= 1'b0;
      s2_i   <= 1'b0;
      s2_a   <= '0;
      s2_s   <= '0;
      o_v    <= 1'b0;
      o_add  <= '0;
      o_sub  <= '0;
    end else begin
      s1_v <= dl_v[DLY-1];
      s2_v <= s1_v;
      o_v  <= s2_v;
      if (dl_v[DLY-1]) begin
        s1_i   <= dl_i[DLY-1];
        s1_sum <= {1'b0, dl_u[DLY-1]} + {1'b0, bf.t_in};
        s1_dif <= {1'b0, dl_u[DLY-1]} - {1'b0, bf.t_in};
      end
      if (s1_v) begin
        s2_i <= s1_i;
        s2_a <= a_red;
        s2_s <= s_red;
      end
      if (s2_v) begin
        o_add <= s2_i ? h_add : s2_a;
        o_sub <= s2_i ? h_sub : s2_s;
      end
    end
  end

  assign bf.out_valid = o_v;
  assign bf.out_add   = o_add;
  assign bf.out_sub   = o_sub;

endmodule
